axis_register_slice: RTL and testbench
======================================

Name: axis_register_slice

Overview:
- Fully registered AXI4-Stream pipeline stage (two-entry skid buffer) placed directly upstream of an AXI-Stream slave port.
- Breaks timing on both the forward path (TVALID and payload) and the backward path (TREADY).
- Sustains one beat per cycle, with no bubbles and no combinational path from input to output.
- Its master port must satisfy every AXI-Stream handshake, stability and reset rule the team's slave-port property set checks.

Parameters:
- byte_width, 4, number of TDATA bytes; TDATA is 8*byte_width bits, TSTRB/TKEEP are byte_width bits.
- id_width, 1, TID width; minimum 1; unused bits are tied to 0 by the integrator.
- dest_width, 1, TDEST width; minimum 1.
- user_width, 1, TUSER width; minimum 1.
- count_width, 32, width of the completed-packet counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  slice can accept a beat; registered.
- s_tdata  input  8*byte_width  upstream payload.
- s_tstrb  input  byte_width  upstream byte qualifier.
- s_tkeep  input  byte_width  upstream byte keep.
- s_tlast  input  1  upstream packet boundary.
- s_tid  input  id_width  upstream stream ID.
- s_tdest  input  dest_width  upstream routing.
- s_tuser  input  user_width  upstream sideband.
- m_tvalid  output  1  downstream beat valid; registered.
- m_tready  input  1  downstream ready.
- m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  output  same widths as s_*  registered payload.
- occupancy  output  2  beats held: 0, 1 or 2.
- pkt_count  output  count_width  number of m-side handshakes with m_tlast=1.

Behaviour:
- Handshakes: s_hs = s_tvalid & s_tready; m_hs = m_tvalid & m_tready.
- Storage: main register drives m_*; skid register holds one overflow beat. The payload bundle is all of tdata, tstrb, tkeep, tlast, tid, tdest and tuser.
- Reset: when resetn=0 at a rising edge, state goes to EMPTY, m_tvalid=0, s_tready=0, occupancy=0, pkt_count=0. Payload registers are not reset (don't-care while invalid).
- First edge with resetn=1: s_tready goes to 1. m_tvalid stays 0 until the first accepted beat.
- Reset mid-operation: buffered beats are discarded and pkt_count is cleared. No beat is emitted afterwards.
- State EMPTY: m_tvalid=0, s_tready=1, occupancy=0.
  - s_hs: load main, go to BUSY.
- State BUSY: m_tvalid=1, s_tready=1, occupancy=1.
  - s_hs & m_hs: load main from s_*, stay BUSY.
  - s_hs & !m_hs: load skid from s_*, go to FULL, s_tready becomes 0.
  - !s_hs & m_hs: go to EMPTY.
  - Neither: hold.
- State FULL: m_tvalid=1, s_tready=0, occupancy=2.
  - m_hs: main <= skid, go to BUSY, s_tready becomes 1.
  - Otherwise hold. No s_hs is possible in this state.
- Latency: a beat accepted at edge N appears on m_* after edge N. Forward latency is 1 cycle; throughput is 1 beat/cycle with m_tready held high.
- s_tready is a pure register output and never depends combinationally on m_tready.
- While m_tvalid & !m_tready, every m_* signal is held stable. m_tvalid never falls without a preceding m_hs, except through reset.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- The payload is passed bit-exact. The slice does not check or modify TKEEP/TSTRB legality.
- pkt_count: +1 on each m_hs with m_tlast=1. It wraps modulo 2^count_width (all-ones +1 gives 0).
- occupancy equals (m_tvalid ? 1 : 0) + (FULL ? 1 : 0) at all times.

Test Plan:
- Reset release: hold resetn=0 for 3 cycles, then raise. Required: s_tready=0 during reset, s_tready=1 one edge after release, m_tvalid=0, pkt_count=0.
- Streaming: m_tready=1; drive tdata=1..8 back-to-back, tlast on beat 8. Required: m_tdata=1..8 on consecutive cycles, each one cycle after input; pkt_count=1; occupancy never exceeds 1.
- Backpressure: m_tready=0; drive tdata=0xA, 0xB, 0xC continuously. Required: 0xA, 0xB accepted, s_tready=0 while 0xC is held, occupancy=2, m_tdata stable at 0xA. Then raise m_tready: output is 0xA, 0xB, 0xC in order, none lost.
- Random valid/ready: 10k cycles with 50% toggling and all signals at max widths. Required: scoreboard exact match, plus m-side stability and reset properties pass with the slave-port monitor attached.
- Counter wrap: count_width=4; send 17 single-beat packets with tlast=1. Required: pkt_count=1 after the 17th.
- Mid-operation reset: reach FULL, pulse resetn=0 for one cycle. Required: m_tvalid=0, occupancy=0, pkt_count=0 next edge; old beats never appear on m_*.

Source files
------------

// File: rtl/axis_register_slice.sv
// AXI4-Stream register slice: a two-entry skid buffer that registers TVALID, TREADY and
// the full payload so that neither the forward nor the backward path is combinational.
module axis_register_slice #(
    parameter int byte_width  = 4,
    parameter int id_width    = 1,
    parameter int dest_width  = 1,
    parameter int user_width  = 1,
    parameter int count_width = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [8*byte_width-1:0]  s_tdata,
    input  logic [byte_width-1:0]    s_tstrb,
    input  logic [byte_width-1:0]    s_tkeep,
    input  logic                     s_tlast,
    input  logic [id_width-1:0]      s_tid,
    input  logic [dest_width-1:0]    s_tdest,
    input  logic [user_width-1:0]    s_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [8*byte_width-1:0]  m_tdata,
    output logic [byte_width-1:0]    m_tstrb,
    output logic [byte_width-1:0]    m_tkeep,
    output logic                     m_tlast,
    output logic [id_width-1:0]      m_tid,
    output logic [dest_width-1:0]    m_tdest,
    output logic [user_width-1:0]    m_tuser,
    output logic [1:0]               occupancy,
    output logic [count_width-1:0]   pkt_count
);

    localparam int data_width   = 8 * byte_width;
    localparam int bundle_width = data_width + 2 * byte_width + 1 + id_width + dest_width + user_width;
    localparam logic [count_width-1:0] count_one = {{(count_width-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                   state_r;
    logic                     m_tvalid_r;
    logic                     s_tready_r;
    logic [1:0]               occupancy_r;
    logic [count_width-1:0]   pkt_count_r;
    logic [bundle_width-1:0]  main_r;
    logic [bundle_width-1:0]  skid_r;

    logic [bundle_width-1:0]  s_bundle_s;
    logic                     s_hs_s;
    logic                     m_hs_s;
    logic                     load_main_s;
    logic                     main_from_skid_s;
    logic                     load_skid_s;

    assign s_bundle_s = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = main_r;

    assign m_tvalid  = m_tvalid_r;
    assign s_tready  = s_tready_r;
    assign occupancy = occupancy_r;
    assign pkt_count = pkt_count_r;

    // Handshakes use only registered ready/valid, so no input reaches an output combinationally.
    assign s_hs_s = s_tvalid & s_tready_r;
    assign m_hs_s = m_tvalid_r & m_tready;

    // Payload steering: which register captures which source on this edge.
    always_comb begin
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (s_hs_s) begin
                    load_main_s = 1'b1;
                end else begin
                    load_main_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (s_hs_s && m_hs_s) begin
                    load_main_s = 1'b1;
                end else if (s_hs_s) begin
                    load_skid_s = 1'b1;
                end else begin
                    load_main_s = 1'b0;
                end
            end
            ST_FULL: begin
                if (m_hs_s) begin
                    main_from_skid_s = 1'b1;
                end else begin
                    main_from_skid_s = 1'b0;
                end
            end
            default: begin
                load_main_s      = 1'b0;
                main_from_skid_s = 1'b0;
                load_skid_s      = 1'b0;
            end
        endcase
    end

    // Control FSM with registered valid, ready, occupancy and packet counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_EMPTY;
            m_tvalid_r  <= 1'b0;
            s_tready_r  <= 1'b0;
            occupancy_r <= 2'd0;
            pkt_count_r <= {count_width{1'b0}};
        end else begin
            if (m_hs_s && m_tlast) begin
                pkt_count_r <= pkt_count_r + count_one;
            end else begin
                pkt_count_r <= pkt_count_r;
            end

            case (state_r)
                ST_EMPTY: begin
                    if (s_hs_s) begin
                        state_r     <= ST_BUSY;
                        m_tvalid_r  <= 1'b1;
                        s_tready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        m_tvalid_r  <= 1'b0;
                        s_tready_r  <= 1'b1;
                        occupancy_r <= 2'd0;
                    end
                end
                ST_BUSY: begin
                    if (s_hs_s && !m_hs_s) begin
                        state_r     <= ST_FULL;
                        m_tvalid_r  <= 1'b1;
                        s_tready_r  <= 1'b0;
                        occupancy_r <= 2'd2;
                    end else if (!s_hs_s && m_hs_s) begin
                        state_r     <= ST_EMPTY;
                        m_tvalid_r  <= 1'b0;
                        s_tready_r  <= 1'b1;
                        occupancy_r <= 2'd0;
                    end else begin
                        state_r     <= ST_BUSY;
                        m_tvalid_r  <= 1'b1;
                        s_tready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end
                end
                ST_FULL: begin
                    if (m_hs_s) begin
                        state_r     <= ST_BUSY;
                        m_tvalid_r  <= 1'b1;
                        s_tready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end else begin
                        state_r     <= ST_FULL;
                        m_tvalid_r  <= 1'b1;
                        s_tready_r  <= 1'b0;
                        occupancy_r <= 2'd2;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean empty slice.
                    state_r     <= ST_EMPTY;
                    m_tvalid_r  <= 1'b0;
                    s_tready_r  <= 1'b1;
                    occupancy_r <= 2'd0;
                end
            endcase
        end
    end

    // Payload registers carry no reset; their contents are ignored while m_tvalid is low.
    always_ff @(posedge clk) begin
        if (load_main_s) begin
            main_r <= s_bundle_s;
        end else if (main_from_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end

        if (load_skid_s) begin
            skid_r <= s_bundle_s;
        end else begin
            skid_r <= skid_r;
        end
    end

endmodule

// File: tb/tb_axis_register_slice.sv
// Directed and randomized checks of axis_register_slice with a queue scoreboard.
module tb_axis_register_slice;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb, s_tkeep, s_tid, s_tdest, s_tuser;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb, m_tkeep, m_tid, m_tdest, m_tuser;
    logic        m_tlast;
    logic [1:0]  occupancy;
    logic [3:0]  pkt_count;

    int tests = 0;
    int fails = 0;

    logic [52:0] q[$];
    logic [52:0] exp_b;
    logic [52:0] prev_m;
    logic        prev_stall;
    logic        pending;
    logic        s_acc;
    logic [3:0]  pkt_exp;

    always #5 clk = ~clk;

    axis_register_slice #(
        .byte_width (4),
        .id_width   (4),
        .dest_width (4),
        .user_width (4),
        .count_width(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tstrb  (s_tstrb),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tid    (s_tid),
        .s_tdest  (s_tdest),
        .s_tuser  (s_tuser),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tstrb  (m_tstrb),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tdest  (m_tdest),
        .m_tuser  (m_tuser),
        .occupancy(occupancy),
        .pkt_count(pkt_count)
    );

    // Bundle layout: data[52:21] strb[20:17] keep[16:13] last[12] id[11:8] dest[7:4] user[3:0]
    function automatic logic [52:0] s_pack();
        return {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    endfunction

    function automatic logic [52:0] m_pack();
        return {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        s_tstrb  = 4'hF;
        s_tkeep  = 4'hF;
        s_tid    = 4'h0;
        s_tdest  = 4'h0;
        s_tuser  = 4'h0;
    endtask

    initial begin
        resetn   = 1'b0;
        m_tready = 1'b0;
        drive(1'b0, 32'h0, 1'b0);

        // Reset release
        repeat (3) cyc();
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_pkt", pkt_count, 4'd0);
        resetn = 1'b1;
        cyc();
        check("rel_s_tready", s_tready, 1'b1);
        check("rel_m_tvalid", m_tvalid, 1'b0);
        check("rel_pkt", pkt_count, 4'd0);

        // Streaming with m_tready high: one beat per cycle, one cycle latency
        m_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), (i == 8));
            cyc();
            check("stream_valid", m_tvalid, 1'b1);
            check("stream_data", m_tdata, 32'(i));
            check("stream_occ", occupancy, 2'd1);
            check("stream_ready", s_tready, 1'b1);
        end
        check("stream_last", m_tlast, 1'b1);
        check("stream_pkt_before", pkt_count, 4'd0);
        drive(1'b0, 32'h0, 1'b0);
        cyc();
        check("stream_drain_valid", m_tvalid, 1'b0);
        check("stream_drain_occ", occupancy, 2'd0);
        check("stream_pkt", pkt_count, 4'd1);

        // Backpressure fills both entries, then drains in order
        m_tready = 1'b0;
        drive(1'b1, 32'hA, 1'b0);
        cyc();
        check("bp_a_data", m_tdata, 32'hA);
        check("bp_a_occ", occupancy, 2'd1);
        check("bp_a_ready", s_tready, 1'b1);
        drive(1'b1, 32'hB, 1'b0);
        cyc();
        check("bp_b_occ", occupancy, 2'd2);
        check("bp_b_ready", s_tready, 1'b0);
        check("bp_b_data", m_tdata, 32'hA);
        drive(1'b1, 32'hC, 1'b0);
        repeat (2) begin
            cyc();
            check("bp_c_ready", s_tready, 1'b0);
            check("bp_c_occ", occupancy, 2'd2);
            check("bp_c_data", m_tdata, 32'hA);
            check("bp_c_valid", m_tvalid, 1'b1);
        end
        m_tready = 1'b1;
        cyc();
        check("bp_out_b", m_tdata, 32'hB);
        check("bp_out_b_occ", occupancy, 2'd1);
        check("bp_out_b_ready", s_tready, 1'b1);
        cyc();
        check("bp_out_c", m_tdata, 32'hC);
        check("bp_out_c_valid", m_tvalid, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        cyc();
        check("bp_empty_valid", m_tvalid, 1'b0);
        check("bp_pkt", pkt_count, 4'd1);

        // Mid-operation reset from FULL discards both beats
        m_tready = 1'b0;
        drive(1'b1, 32'h11, 1'b1);
        cyc();
        drive(1'b1, 32'h22, 1'b1);
        cyc();
        check("mrst_full_occ", occupancy, 2'd2);
        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        cyc();
        check("mrst_valid", m_tvalid, 1'b0);
        check("mrst_occ", occupancy, 2'd0);
        check("mrst_pkt", pkt_count, 4'd0);
        check("mrst_ready", s_tready, 1'b0);
        resetn   = 1'b1;
        m_tready = 1'b1;
        cyc();
        check("mrst_rel_ready", s_tready, 1'b1);
        repeat (3) begin
            check("mrst_no_ghost", m_tvalid, 1'b0);
            cyc();
        end
        check("mrst_pkt_after", pkt_count, 4'd0);

        // Counter wrap at 4 bits: 17 single-beat packets
        for (int k = 1; k <= 17; k++) begin
            drive(1'b1, 32'h100 + 32'(k), 1'b1);
            cyc();
        end
        check("wrap_16", pkt_count, 4'd0);
        drive(1'b0, 32'h0, 1'b0);
        cyc();
        check("wrap_17", pkt_count, 4'd1);

        // Random valid/ready with scoreboard, hold and occupancy checks
        pkt_exp    = 4'd1;
        prev_stall = 1'b0;
        pending    = 1'b0;
        prev_m     = '0;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_occ", occupancy, 64'(q.size()));
            check("rnd_valid", m_tvalid, (q.size() != 0));
            if (prev_stall) begin
                check("rnd_hold_valid", m_tvalid, 1'b1);
                check("rnd_hold_data", m_pack(), prev_m);
            end
            if (!pending) begin
                s_tvalid = 1'($urandom_range(0, 1));
                s_tdata  = $urandom;
                s_tstrb  = 4'($urandom);
                s_tkeep  = 4'($urandom);
                s_tlast  = 1'($urandom_range(0, 1));
                s_tid    = 4'($urandom);
                s_tdest  = 4'($urandom);
                s_tuser  = 4'($urandom);
            end
            m_tready = 1'($urandom_range(0, 1));
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", m_tvalid, 1'b0);
                end else begin
                    exp_b = q.pop_front();
                    check("rnd_data", m_pack(), exp_b);
                    if (exp_b[12]) pkt_exp = pkt_exp + 4'd1;
                end
            end
            s_acc = s_tvalid && s_tready;
            if (s_acc) q.push_back(s_pack());
            pending    = s_tvalid && !s_acc;
            prev_stall = m_tvalid && !m_tready;
            prev_m     = m_pack();
            cyc();
        end

        // Drain, bounded to a few cycles
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (m_tvalid) begin
                if (q.size() == 0) begin
                    check("drain_spurious", m_tvalid, 1'b0);
                end else begin
                    exp_b = q.pop_front();
                    check("drain_data", m_pack(), exp_b);
                    if (exp_b[12]) pkt_exp = pkt_exp + 4'd1;
                end
            end
            cyc();
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        check("drain_valid", m_tvalid, 1'b0);
        check("rnd_pkt", pkt_count, pkt_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
